// File: rtl/deskew_matrix.sv
// Reassembles a diagonal wavefront stream (2*SIZE-1 beats) into a SIZE x SIZE matrix.
// Two ping-pong banks let a new frame arrive while the previous one waits on out_ready.
module deskew_matrix #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SIZE  = 3
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [SIZE*WIDTH-1:0]         in_vec,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [SIZE*SIZE*WIDTH-1:0]    out_matrix,
    output logic                          overflow,
    output logic                          busy
);

    localparam int unsigned BEATS = 2 * SIZE - 1;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned ELEMS = SIZE * SIZE;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [1:0]       bank_full_q, bank_full_d;
    logic             frame_drop_q, frame_drop_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] bank_q [2][ELEMS];
    logic [WIDTH-1:0] bank_d [2][ELEMS];

    logic first_beat_c;
    logic last_beat_c;
    logic drop_c;
    logic write_en_c;
    logic drain_c;

    // Beat 0 decides the drop from registered occupancy; later beats reuse the latched decision
    always_comb begin
        first_beat_c = in_valid && (beat_cnt_q == '0);
        last_beat_c  = in_valid && (beat_cnt_q == LAST_BEAT);
        drop_c       = first_beat_c ? bank_full_q[wr_bank_q] : frame_drop_q;
        write_en_c   = in_valid && !drop_c;
        drain_c      = bank_full_q[rd_bank_q] && out_ready;
    end

    always_comb begin
        beat_cnt_d   = beat_cnt_q;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        bank_full_d  = bank_full_q;
        frame_drop_d = frame_drop_q;
        overflow_d   = overflow_q;

        if (in_valid) begin
            beat_cnt_d = last_beat_c ? '0 : beat_cnt_q + CNT_W'(1);
        end
        if (first_beat_c) begin
            frame_drop_d = bank_full_q[wr_bank_q];
            if (bank_full_q[wr_bank_q]) begin
                overflow_d = 1'b1;
            end
        end
        if (last_beat_c && !drop_c) begin
            bank_full_d[wr_bank_q] = 1'b1;
            wr_bank_d              = ~wr_bank_q;
        end
        // Completion and drain never target the same bank, so both updates apply
        if (drain_c) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = ~rd_bank_q;
        end
    end

    // Element M[r][c] arrives on lane c during beat r+c
    always_comb begin
        bank_d = bank_q;
        for (int unsigned r = 0; r < SIZE; r++) begin
            for (int unsigned c = 0; c < SIZE; c++) begin
                if (write_en_c && (beat_cnt_q == CNT_W'(r + c))) begin
                    bank_d[wr_bank_q][r*SIZE+c] = in_vec[c*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            beat_cnt_q   <= '0;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            bank_full_q  <= '0;
            frame_drop_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            beat_cnt_q   <= beat_cnt_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            bank_full_q  <= bank_full_d;
            frame_drop_q <= frame_drop_d;
            overflow_q   <= overflow_d;
        end
    end

    // Bank storage carries no reset; contents are only observed behind out_valid
    always_ff @(posedge clock) begin
        bank_q <= bank_d;
    end

    always_comb begin
        out_matrix = '0;
        for (int unsigned e = 0; e < ELEMS; e++) begin
            out_matrix[e*WIDTH +: WIDTH] = bank_q[rd_bank_q][e];
        end
        out_valid = bank_full_q[rd_bank_q];
        overflow  = overflow_q;
        busy      = (beat_cnt_q != '0);
    end

endmodule

// File: tb/tb_deskew_matrix.sv
// Self-checking bench for deskew_matrix: directed scenarios plus a randomized run
// compared against a frame-level queue model.
module tb_deskew_matrix;

    localparam int unsigned W     = 4;
    localparam int unsigned S     = 3;
    localparam int unsigned VW    = S * W;
    localparam int unsigned MW    = S * S * W;
    localparam int          LAST  = 2 * S - 2;

    typedef logic [MW-1:0] mat_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [VW-1:0] in_vec = '0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [MW-1:0] out_matrix;
    logic          overflow;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    // Frame-level model: pending matrices in arrival order, beat position, drop state
    mat_t q[$];
    mat_t cur;
    int   bidx = 0;
    bit   drop_m = 0;
    bit   ovf_m = 0;

    deskew_matrix #(.WIDTH(W), .SIZE(S)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_vec     (in_vec),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_matrix (out_matrix),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [W-1:0] get_el(input mat_t m, input int r, input int c);
        return m[(r*S+c)*W +: W];
    endfunction

    function automatic mat_t rand_mat();
        mat_t m;
        for (int e = 0; e < S*S; e++) m[e*W +: W] = W'($urandom);
        return m;
    endfunction

    // Drives one cycle (called at posedge+1) and advances the model at the edge
    task automatic tick(input bit v, input bit rdy, input bit dc_f);
        bit acc;
        in_valid  = v;
        out_ready = rdy;
        for (int t = 0; t < S; t++) begin
            int r;
            r = bidx - t;
            if (v && r >= 0 && r < S) in_vec[t*W +: W] = get_el(cur, r, t);
            else in_vec[t*W +: W] = dc_f ? W'('hF) : W'($urandom);
        end
        @(posedge clock);
        acc = (q.size() != 0) && rdy;
        if (v) begin
            if (bidx == 0) begin
                drop_m = (q.size() == 2);
                if (drop_m) ovf_m = 1;
            end
            if (bidx == LAST && !drop_m) q.push_back(cur);
            bidx = (bidx == LAST) ? 0 : bidx + 1;
        end
        if (acc) void'(q.pop_front());
        #1;
    endtask

    task automatic send_frame(input mat_t m, input bit rdy, input int gap, input bit dc_f);
        cur = m;
        for (int b = 0; b <= LAST; b++) begin
            tick(1'b1, rdy, dc_f);
            if (b != LAST) repeat (gap) tick(1'b0, rdy, 1'b0);
        end
    endtask

    task automatic model_reset();
        q.delete();
        bidx   = 0;
        drop_m = 0;
        ovf_m  = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        model_reset();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++;
        if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        mat_t m;
        m = MW'(36'h987654321);
        send_frame(m, 1'b1, 0, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid: got %b expected 1", out_valid); end
        n_cmp++;
        if (out_matrix !== MW'(36'h987654321)) begin n_err++; $display("FAIL b2b_matrix: got %h expected 987654321", out_matrix); end
        tick(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_single_cycle: got %b expected 0", out_valid); end
    endtask

    task automatic test_gaps();
        cur = MW'(36'h987654321);
        for (int b = 0; b <= LAST; b++) begin
            tick(1'b1, 1'b1, 1'b1);
            if (b != LAST) begin
                repeat (2) tick(1'b0, 1'b1, 1'b1);
                n_cmp++;
                if (busy !== 1'b1) begin n_err++; $display("FAIL gap_busy_b%0d: got %b expected 1", b, busy); end
            end
        end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL gap_busy_end: got %b expected 0", busy); end
        n_cmp++;
        if (out_valid !== 1'b1 || out_matrix !== MW'(36'h987654321)) begin
            n_err++; $display("FAIL gap_matrix: got v=%b %h expected v=1 987654321", out_valid, out_matrix);
        end
        tick(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_hold_then_drain();
        mat_t a, b;
        a = rand_mat();
        b = rand_mat();
        send_frame(a, 1'b0, 0, 1'b0);
        send_frame(b, 1'b0, 1, 1'b0);
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_matrix !== a) begin
            n_err++; $display("FAIL hold_a: got v=%b %h expected v=1 %h", out_valid, out_matrix, a);
        end
        tick(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_matrix !== b) begin
            n_err++; $display("FAIL hold_b_next: got v=%b %h expected v=1 %h", out_valid, out_matrix, b);
        end
        tick(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL hold_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_overflow();
        mat_t f1, f2, f3;
        f1 = rand_mat();
        f2 = rand_mat();
        f3 = rand_mat();
        send_frame(f1, 1'b0, 0, 1'b0);
        send_frame(f2, 1'b0, 0, 1'b0);
        n_cmp++;
        if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b expected 0", overflow); end
        cur = f3;
        tick(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        for (int b = 1; b <= LAST; b++) tick(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (out_matrix !== f1) begin n_err++; $display("FAIL ovf_f1: got %h expected %h", out_matrix, f1); end
        tick(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_matrix !== f2) begin
            n_err++; $display("FAIL ovf_f2: got v=%b %h expected v=1 %h", out_valid, out_matrix, f2);
        end
        tick(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b0 || overflow !== 1'b1) begin
            n_err++; $display("FAIL ovf_after_drain: got v=%b ovf=%b expected v=0 ovf=1", out_valid, overflow);
        end
    endtask

    task automatic test_reset_midframe();
        mat_t p, n;
        p = rand_mat();
        n = rand_mat();
        cur = p;
        repeat (3) tick(1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
            n_cmp++;
            if (out_valid !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0) begin
                n_err++; $display("FAIL midreset_outputs: got v=%b ovf=%b busy=%b expected 0 0 0", out_valid, overflow, busy);
            end
        end
        model_reset();
        reset = 1'b0;
        send_frame(n, 1'b1, 0, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_matrix !== n) begin
            n_err++; $display("FAIL midreset_frame: got v=%b %h expected v=1 %h", out_valid, out_matrix, n);
        end
        tick(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL midreset_only_one: got %b expected 0", out_valid); end
    endtask

    task automatic test_simul_drain();
        mat_t a, b;
        a = rand_mat();
        b = rand_mat();
        send_frame(a, 1'b0, 0, 1'b0);
        cur = b;
        for (int i = 0; i < LAST; i++) tick(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (out_matrix !== a) begin n_err++; $display("FAIL simul_pre: got %h expected %h", out_matrix, a); end
        tick(1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_matrix !== b) begin
            n_err++; $display("FAIL simul_bank1: got v=%b %h expected v=1 %h", out_valid, out_matrix, b);
        end
        tick(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL simul_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bit v, rdy;
            v   = ($urandom_range(0, 9) < 7);
            rdy = ($urandom_range(0, 9) < 4);
            if (v && bidx == 0) cur = rand_mat();
            tick(v, rdy, 1'b0);
            n_cmp++;
            if (out_valid !== (q.size() != 0) || overflow !== ovf_m || busy !== (bidx != 0)) begin
                n_err++;
                $display("FAIL rand_ctrl cyc%0d: got v=%b ovf=%b busy=%b expected v=%b ovf=%b busy=%b",
                         i, out_valid, overflow, busy, q.size() != 0, ovf_m, bidx != 0);
            end
            if (q.size() != 0) begin
                n_cmp++;
                if (out_matrix !== q[0]) begin
                    n_err++; $display("FAIL rand_matrix cyc%0d: got %h expected %h", i, out_matrix, q[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_hold_then_drain();
        test_overflow();
        test_reset_midframe();
        test_reset();
        test_simul_drain();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
